// File: rtl/cia_pkg.sv
// Shared constants and helpers for the pipelined carry-increment adder.
package cia_pkg;

   localparam int unsigned CIA_DEF_W  = 16;
   localparam int unsigned CIA_DEF_GS = 4;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   function automatic int unsigned cia_num_groups(input int unsigned w, input int unsigned gs);
      return w / gs;
   endfunction

endpackage

// File: rtl/cia_group.sv
// One carry-increment group: generate/propagate plus both candidate sums.
module cia_group
   import cia_pkg::*;
#(
   parameter int unsigned GS = CIA_DEF_GS
) (
   input  logic [GS-1:0] i_a,
   input  logic [GS-1:0] i_b,
   output logic          o_g,
   output logic          o_p,
   output logic [GS-1:0] o_sum0,
   output logic [GS-1:0] o_sum1
);

   logic [GS:0] w_add0;
   logic [GS:0] w_add1;

   assign w_add0 = {1'b0, i_a} + {1'b0, i_b};
   assign w_add1 = {1'b0, i_a} + {1'b0, i_b} + {{GS{1'b0}}, 1'b1};

   // P is "every bit propagates", so carry_out = G | (P & carry_in).
   assign o_g    = w_add0[GS];
   assign o_p    = &(i_a ^ i_b);
   assign o_sum0 = w_add0[GS-1:0];
   assign o_sum1 = w_add1[GS-1:0];

endmodule

// File: rtl/pipe_cia_adder.sv
// Two-stage valid/ready carry-increment adder/subtractor.
// Optional signed-overflow output enabled by defining CIA_OVF_EN.
module pipe_cia_adder
   import cia_pkg::*;
#(
   parameter int unsigned W  = CIA_DEF_W,
   parameter int unsigned GS = CIA_DEF_GS
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   input  logic         op_sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] sum,
`ifdef CIA_OVF_EN
   output logic         ovf,
`endif
   output logic         cout
);

   localparam int unsigned NG = cia_num_groups(W, GS);

   if ((W % GS) != 0) begin : g_bad_gs
      $error("pipe_cia_adder: W must be a multiple of GS");
   end

   logic [W-1:0]  w_b_eff;
   logic          w_cin_eff;
   logic [NG-1:0] w_g;
   logic [NG-1:0] w_p;
   logic [W-1:0]  w_sum0;
   logic [W-1:0]  w_sum1;
   logic          w_stall;
   logic [NG:0]   w_c;
   logic [W-1:0]  w_fsum;

   logic          r_s1_valid;
   logic [NG-1:0] r_s1_g;
   logic [NG-1:0] r_s1_p;
   logic [W-1:0]  r_s1_sum0;
   logic [W-1:0]  r_s1_sum1;
   logic          r_s1_cin;
   logic          r_s2_valid;
   logic [W-1:0]  r_s2_sum;
   logic          r_s2_cout;
`ifdef CIA_OVF_EN
   logic          r_s1_axb_msb;
   logic          r_s2_ovf;
`endif

   // Subtract as A + ~B + 1; caller's cin is ignored then.
   assign w_b_eff   = (op_sub == OP_SUB) ? ~b : b;
   assign w_cin_eff = (op_sub == OP_SUB) ? 1'b1 : cin;

   for (genvar k = 0; k < NG; k++) begin : g_grp
      cia_group #(
         .GS (GS)
      ) u_grp (
         .i_a    (a[k*GS +: GS]),
         .i_b    (w_b_eff[k*GS +: GS]),
         .o_g    (w_g[k]),
         .o_p    (w_p[k]),
         .o_sum0 (w_sum0[k*GS +: GS]),
         .o_sum1 (w_sum1[k*GS +: GS])
      );
   end

   always_comb begin
      w_c    = '0;
      w_fsum = '0;
      w_c[0] = r_s1_cin;
      for (int k = 0; k < NG; k++) begin
         w_c[k+1]           = r_s1_g[k] | (r_s1_p[k] & w_c[k]);
         w_fsum[k*GS +: GS] = w_c[k] ? r_s1_sum1[k*GS +: GS] : r_s1_sum0[k*GS +: GS];
      end
   end

   // Whole pipe freezes while the output beat is blocked.
   assign w_stall  = r_s2_valid && !out_ready;
   assign in_ready = !w_stall;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_g     <= '0;
         r_s1_p     <= '0;
         r_s1_sum0  <= '0;
         r_s1_sum1  <= '0;
         r_s1_cin   <= 1'b0;
         r_s2_valid <= 1'b0;
         r_s2_sum   <= '0;
         r_s2_cout  <= 1'b0;
      end else if (!w_stall) begin
         r_s1_valid <= in_valid;
         r_s2_valid <= r_s1_valid;
         if (in_valid) begin
            r_s1_g    <= w_g;
            r_s1_p    <= w_p;
            r_s1_sum0 <= w_sum0;
            r_s1_sum1 <= w_sum1;
            r_s1_cin  <= w_cin_eff;
         end
         if (r_s1_valid) begin
            r_s2_sum  <= w_fsum;
            r_s2_cout <= w_c[NG];
         end
      end
   end

`ifdef CIA_OVF_EN
   // Carry into the MSB is recovered as a^b^sum at that bit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_axb_msb <= 1'b0;
         r_s2_ovf     <= 1'b0;
      end else if (!w_stall) begin
         if (in_valid) begin
            r_s1_axb_msb <= a[W-1] ^ w_b_eff[W-1];
         end
         if (r_s1_valid) begin
            r_s2_ovf <= r_s1_axb_msb ^ w_fsum[W-1] ^ w_c[NG];
         end
      end
   end

   assign ovf = r_s2_ovf;
`endif

   assign out_valid = r_s2_valid;
   assign sum       = r_s2_sum;
   assign cout      = r_s2_cout;

endmodule

// File: tb/tb_pipe_cia_adder.sv
// Self-checking bench: directed W=16/GS=4 steps, then random W=32/GS=8 traffic
// against an arithmetic reference model.
module tb_pipe_cia_adder;

   localparam int unsigned W1 = 16;
   localparam int unsigned GS1 = 4;
   localparam int unsigned W2 = 32;
   localparam int unsigned GS2 = 8;
   localparam int unsigned NRAND = 10000;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic          d1_in_valid, d1_in_ready, d1_cin, d1_op_sub;
   logic          d1_out_valid, d1_out_ready, d1_cout;
   logic [W1-1:0] d1_a, d1_b, d1_sum;
   logic          d2_in_valid, d2_in_ready, d2_cin, d2_op_sub;
   logic          d2_out_valid, d2_out_ready, d2_cout;
   logic [W2-1:0] d2_a, d2_b, d2_sum;
`ifdef CIA_OVF_EN
   logic          d1_ovf, d2_ovf;
`endif

   pipe_cia_adder #(.W(W1), .GS(GS1)) u_dut16 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (d1_in_valid),
      .in_ready  (d1_in_ready),
      .a         (d1_a),
      .b         (d1_b),
      .cin       (d1_cin),
      .op_sub    (d1_op_sub),
      .out_valid (d1_out_valid),
      .out_ready (d1_out_ready),
      .sum       (d1_sum),
`ifdef CIA_OVF_EN
      .ovf       (d1_ovf),
`endif
      .cout      (d1_cout)
   );

   pipe_cia_adder #(.W(W2), .GS(GS2)) u_dut32 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (d2_in_valid),
      .in_ready  (d2_in_ready),
      .a         (d2_a),
      .b         (d2_b),
      .cin       (d2_cin),
      .op_sub    (d2_op_sub),
      .out_valid (d2_out_valid),
      .out_ready (d2_out_ready),
      .sum       (d2_sum),
`ifdef CIA_OVF_EN
      .ovf       (d2_ovf),
`endif
      .cout      (d2_cout)
   );

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [W2-1:0] s;
      logic          c;
      logic          o;
   } res_t;

   res_t exp_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Plain integer arithmetic, independent of any group structure.
   function automatic res_t model32(input logic [31:0] a, input logic [31:0] b,
                                    input logic ci, input logic sub);
      res_t r;
      longint unsigned ua = 64'(a);
      longint unsigned ub = 64'(b);
      longint unsigned full;
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint sr;
      full = sub ? (ua - ub) : (ua + ub + 64'(ci));
      sr   = sub ? (sa - sb) : (sa + sb + longint'(ci));
      r.s  = full[31:0];
      r.c  = sub ? (ua >= ub) : full[32];
      r.o  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      return r;
   endfunction

   task automatic send1(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic sub, input logic [15:0] es,
                        input logic ec, input logic eo);
      @(negedge clk);
      d1_in_valid = 1'b1; d1_a = a; d1_b = b; d1_cin = ci; d1_op_sub = sub;
      d1_out_ready = 1'b1;
      #1 chk({tag, "_in_ready"}, 64'(d1_in_ready), 64'd1);
      @(negedge clk);
      d1_in_valid = 1'b0;
      #1 chk({tag, "_lat1_valid"}, 64'(d1_out_valid), 64'd0);
      @(negedge clk);
      #1 chk({tag, "_lat2_valid"}, 64'(d1_out_valid), 64'd1);
      chk({tag, "_sum"}, 64'(d1_sum), 64'(es));
      chk({tag, "_cout"}, 64'(d1_cout), 64'(ec));
`ifdef CIA_OVF_EN
      chk({tag, "_ovf"}, 64'(d1_ovf), 64'(eo));
`else
      if (eo) begin end
`endif
   endtask

   initial begin
      int acc, got, idx, stale, sent, recv;
      logic [31:0] ra, rb;
      res_t e;

      rst_n = 1'b0;
      d1_in_valid = 0; d1_a = '0; d1_b = '0; d1_cin = 0; d1_op_sub = 0; d1_out_ready = 1;
      d2_in_valid = 0; d2_a = '0; d2_b = '0; d2_cin = 0; d2_op_sub = 0; d2_out_ready = 1;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      #1 chk("rst_out_valid", 64'(d1_out_valid), 64'd0);
      chk("rst_sum", 64'(d1_sum), 64'd0);
      chk("rst_cout", 64'(d1_cout), 64'd0);
      chk("rst_in_ready", 64'(d1_in_ready), 64'd1);
      chk("rst32_out_valid", 64'(d2_out_valid), 64'd0);
      rst_n = 1'b1;

      // Directed arithmetic, including wrap and borrow cases
      send1("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      send1("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      send1("sub_noborrow", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
      send1("add_cin", 16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);
      send1("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      send1("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

      // Back-pressure: only two beats fit while the output is blocked
      idx = 1; acc = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         d1_out_ready = 1'b0;
         d1_in_valid = 1'b1; d1_a = 16'(idx); d1_b = 16'(idx); d1_cin = 0; d1_op_sub = 0;
         #1 if (d1_in_valid && d1_in_ready) begin acc++; idx++; end
      end
      chk("stall_accepted", 64'(acc), 64'd2);
      chk("stall_in_ready", 64'(d1_in_ready), 64'd0);
      got = 0;
      for (int c = 0; c < 16 && got < 4; c++) begin
         @(negedge clk);
         d1_out_ready = 1'b1;
         d1_in_valid = (idx <= 4); d1_a = 16'(idx); d1_b = 16'(idx);
         #1;
         if (d1_out_valid && d1_out_ready) begin
            got++;
            chk("drain_sum", 64'(d1_sum), 64'(2 * got));
         end
         if (d1_in_valid && d1_in_ready) idx++;
      end
      chk("drain_count", 64'(got), 64'd4);
      @(negedge clk);
      d1_in_valid = 1'b0;

      // Reset with two beats in flight
      @(negedge clk);
      d1_in_valid = 1'b1; d1_a = 16'h0010; d1_b = 16'h0020;
      @(negedge clk);
      d1_a = 16'h0030; d1_b = 16'h0040;
      @(negedge clk);
      d1_in_valid = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("midrst_out_valid", 64'(d1_out_valid), 64'd0);
      chk("midrst_sum", 64'(d1_sum), 64'd0);
      chk("midrst_in_ready", 64'(d1_in_ready), 64'd1);
      stale = 0;
      repeat (6) begin
         @(negedge clk);
         #1 if (d1_out_valid) stale++;
      end
      chk("midrst_stale", 64'(stale), 64'd0);

      // Random traffic on the 32-bit instance with random back-pressure
      sent = 0; recv = 0;
      for (int c = 0; c < 60000 && (sent < NRAND || exp_q.size() > 0); c++) begin
         @(negedge clk);
         ra = $urandom; rb = $urandom;
         case ($urandom_range(7))
            0: ra = 32'hFFFF_FFFF;
            1: rb = 32'h8000_0000;
            2: ra = 32'h7FFF_FFFF;
            3: rb = 32'h0000_0000;
            default: ;
         endcase
         d2_in_valid  = (sent < NRAND) && ($urandom_range(99) < 80);
         d2_a = ra; d2_b = rb; d2_cin = 1'($urandom); d2_op_sub = 1'($urandom);
         d2_out_ready = ($urandom_range(99) < 70);
         #1;
         if (d2_out_valid && d2_out_ready) begin
            recv++;
            if (exp_q.size() == 0) begin
               chk("rand_unexpected_beat", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("rand_sum", 64'(d2_sum), 64'(e.s));
               chk("rand_cout", 64'(d2_cout), 64'(e.c));
`ifdef CIA_OVF_EN
               chk("rand_ovf", 64'(d2_ovf), 64'(e.o));
`endif
            end
         end
         if (d2_in_valid && d2_in_ready) begin
            exp_q.push_back(model32(d2_a, d2_b, d2_cin, d2_op_sub));
            sent++;
         end
      end
      chk("rand_sent", 64'(sent), 64'(NRAND));
      chk("rand_recv", 64'(recv), 64'(NRAND));
      chk("rand_pending", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
